instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/instr_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared core definitions for the instruction fetch slice: widths, reset PC,
// PC increment and the buffered instruction payload.
package instr_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

    // Force a target onto a word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between memory responses and decode: parameterised
// depth, synchronous flush, occupancy count.
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         empty,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A full buffer still takes a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: credit-limited sequential requests to instruction memory,
// in-order response buffering, redirect with drop of stale responses.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    logic [0:0]      state_q, state_nxt;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_nxt;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_nxt;
    logic [CW-1:0]   outstanding_q, outstanding_nxt;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_nxt;
    logic            req_valid_q, req_valid_nxt;
    logic [CW-1:0]   fifo_count, fifo_count_nxt;
    logic            fifo_empty;
    logic            req_fire;
    logic            drop_rsp;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_tgt;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    assign req_fire     = req_valid_q && imem_req_ready;
    assign drop_rsp     = imem_rsp_valid && (redirect_valid || (drop_cnt_q != '0));
    assign push         = imem_rsp_valid && !drop_rsp;
    assign pop          = !fifo_empty && inst_ready;
    assign redirect_tgt = align_pc(redirect_pc);
    assign push_entry   = '{pc: rsp_pc_q, data: imem_rsp_data};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next-state logic: fetch_en alone moves between IDLE and FETCH.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (fetch_en)  state_nxt = FETCH;
            FETCH:   if (!fetch_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, PCs and the registered request-valid.
    always_comb begin
        outstanding_nxt = outstanding_q;
        drop_cnt_nxt    = drop_cnt_q;
        fetch_pc_nxt    = fetch_pc_q;
        rsp_pc_nxt      = rsp_pc_q;
        fifo_count_nxt  = fifo_count;
        req_valid_nxt   = 1'b0;

        if (req_fire && !imem_rsp_valid) begin
            outstanding_nxt = outstanding_q + CW'(1);
        end else if (!req_fire && imem_rsp_valid && (outstanding_q != '0)) begin
            outstanding_nxt = outstanding_q - CW'(1);
        end

        // Every request still in flight after a redirect belongs to the old path.
        if (redirect_valid) begin
            drop_cnt_nxt   = outstanding_nxt;
            fetch_pc_nxt   = redirect_tgt;
            rsp_pc_nxt     = redirect_tgt;
            fifo_count_nxt = '0;
        end else begin
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_nxt = drop_cnt_q - CW'(1);
            end
            if (req_fire) begin
                fetch_pc_nxt = fetch_pc_q + PC_INC;
            end
            if (push) begin
                rsp_pc_nxt = rsp_pc_q + PC_INC;
            end
            fifo_count_nxt = fifo_count + CW'(push) - CW'(pop);
        end

        // Credits cover buffered entries plus every request in flight, dropped or not.
        req_valid_nxt = (state_nxt == FETCH) &&
                        ((SW'(outstanding_nxt) + SW'(fifo_count_nxt)) < SW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            req_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            fetch_pc_q    <= fetch_pc_nxt;
            rsp_pc_q      <= rsp_pc_nxt;
            outstanding_q <= outstanding_nxt;
            drop_cnt_q    <= drop_cnt_nxt;
            req_valid_q   <= req_valid_nxt;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = fetch_pc_q;
    assign inst_valid     = !fifo_empty;
    assign inst_data      = fifo_empty ? '0 : head.data;
    assign inst_pc        = fifo_empty ? '0 : head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order instruction memory model
// (data = ~address, one-cycle latency, optional hold).
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int          n_asserts = 0;
    int          n_fails   = 0;
    logic [31:0] exp_pc;
    logic        mem_hold;
    logic        acc_seen;
    logic [31:0] acc_addr;
    logic [31:0] pend_q[$];

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: note acceptance mid-cycle, answer in order one cycle later.
    always @(negedge clk) begin
        acc_seen = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
    end

    always @(posedge clk) begin
        logic [31:0] a;
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (!rst_n) begin
            pend_q.delete();
        end else begin
            if (acc_seen) pend_q.push_back(acc_addr);
            if (!mem_hold && pend_q.size() > 0) begin
                a = pend_q.pop_front();
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = ~a;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next instruction, check it against exp_pc, consume it.
    task automatic expect_next(input string tag);
        int n = 0;
        while (!inst_valid && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
        chk({tag, "_pc"}, inst_pc, exp_pc);
        chk({tag, "_data"}, inst_data, ~exp_pc);
        exp_pc = exp_pc + 32'd4;
        tick();
    endtask

    initial begin
        int          n_acc;
        logic        stable;
        logic        found;
        logic [31:0] hold_pc;
        logic [31:0] hold_data;

        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        mem_hold       = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);

        // Sequential fetch, ready memory, one-cycle response latency
        rst_n      = 1'b1;
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        tick();
        chk("seq_req0_valid", 32'(imem_req_valid), 32'd1);
        chk("seq_req0_addr", imem_req_addr, 32'h0);
        tick();
        chk("seq_req1_addr", imem_req_addr, 32'h4);
        chk("seq_inst_not_yet", 32'(inst_valid), 32'd0);
        tick();
        chk("seq_inst_latency", 32'(inst_valid), 32'd1);
        exp_pc = 32'h0;
        expect_next("seq0");
        expect_next("seq4");
        expect_next("seq8");

        // Decode stall: buffer fills, at most two issues, head stable
        inst_ready = 1'b0;
        hold_pc    = inst_pc;
        hold_data  = inst_data;
        n_acc      = 0;
        stable     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (imem_req_valid && imem_req_ready) n_acc++;
            tick();
            if (inst_pc !== hold_pc || inst_data !== hold_data) stable = 1'b0;
        end
        chk("stall_head_pc", hold_pc, 32'hC);
        chk("stall_stable", 32'(stable), 32'd1);
        chk("stall_max_issue", 32'(n_acc <= 2), 32'd1);
        chk("stall_no_req", 32'(imem_req_valid), 32'd0);
        inst_ready = 1'b1;
        expect_next("resumeC");
        expect_next("resume10");
        expect_next("resume14");

        // Redirect with two requests outstanding behind a held memory
        mem_hold = 1'b1;
        repeat (6) tick();
        chk("hold_no_req", 32'(imem_req_valid), 32'd0);
        chk("hold_empty", 32'(inst_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("redir_addr", imem_req_addr, 32'h100);
        chk("redir_credit", 32'(imem_req_valid), 32'd0);
        mem_hold = 1'b0;
        exp_pc   = 32'h100;
        expect_next("redir100");
        expect_next("redir104");

        // Redirect coinciding with an inst handshake and a response
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (inst_valid && imem_rsp_valid) found = 1'b1;
            else tick();
        end
        chk("coinc_found", 32'(found), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("coinc_flushed", 32'(inst_valid), 32'd0);
        chk("coinc_addr", imem_req_addr, 32'h100);
        exp_pc = 32'h100;
        expect_next("coinc100");
        expect_next("coinc104");

        // Unaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        tick();
        redirect_valid = 1'b0;
        chk("unal_addr", imem_req_addr, 32'h100);
        exp_pc = 32'h100;
        expect_next("unal100");

        // IDLE keeps draining the buffer but issues nothing
        inst_ready = 1'b0;
        repeat (8) tick();
        chk("idle_full_valid", 32'(inst_valid), 32'd1);
        chk("idle_full_pc", inst_pc, 32'h104);
        fetch_en = 1'b0;
        repeat (2) tick();
        chk("idle_no_req", 32'(imem_req_valid), 32'd0);
        inst_ready = 1'b1;
        expect_next("idle104");
        expect_next("idle108");
        repeat (3) tick();
        chk("idle_drained", 32'(inst_valid), 32'd0);
        chk("idle_still_no_req", 32'(imem_req_valid), 32'd0);

        // Reset with a full buffer
        fetch_en   = 1'b1;
        inst_ready = 1'b0;
        repeat (8) tick();
        chk("prerst_full", 32'(inst_valid), 32'd1);
        rst_n    = 1'b0;
        fetch_en = 1'b0;
        tick();
        chk("midrst_inst_valid", 32'(inst_valid), 32'd0);
        chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("midrst_inst_data", inst_data, 32'h0);
        chk("midrst_inst_pc", inst_pc, 32'h0);
        chk("midrst_addr", imem_req_addr, 32'h0);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("postrst_idle", 32'(imem_req_valid), 32'd0);
        chk("postrst_no_stale", 32'(inst_valid), 32'd0);
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        exp_pc     = 32'h0;
        expect_next("postrst0");
        expect_next("postrst4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
